// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like bus: master IDs, field widths and
// the packed request bundle used to mux a master onto the slave port.
package sram_like_pkg;

   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SIZE_W = 2;
   localparam int STRB_W = 4;

   // wr + size + addr + wstrb + wdata
   localparam int SRAM_REQ_BUS_WD = 1 + SIZE_W + ADDR_W + STRB_W + DATA_W;

   typedef struct packed {
      logic              wr;
      logic [SIZE_W-1:0] size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
   } sram_req_t;

   // Bundle one master's request fields so the arbiter muxes a single word.
   function automatic sram_req_t pack_req(input logic              wr,
                                          input logic [SIZE_W-1:0] size,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [STRB_W-1:0] wstrb,
                                          input logic [DATA_W-1:0] wdata);
      sram_req_t r;
      r.wr    = wr;
      r.size  = size;
      r.addr  = addr;
      r.wstrb = wstrb;
      r.wdata = wdata;
      return r;
   endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of 1-bit master IDs, one entry per outstanding transaction.
// Push is ignored when full and pop is ignored when empty, so a spurious
// pop leaves pointers and count untouched.
module id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  logic pop_i,
   input  logic din_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DEPTH-1:0] slot_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = slot_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next-state for pointers (wrap naturally at DEPTH) and occupancy count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state: pointers and count, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage; stale entries are never read because count guards head.
   always_ff @(posedge clk) begin
      if (do_push) begin
         slot_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like arbiter. Grants the address
// phase with data priority and a lock that holds a stalled grant, records the
// owner of every accepted address in an ID FIFO, and steers dataok back to
// the owner in order.
module sram_like_arbiter
   import sram_like_pkg::*;
#(
   parameter int OUTSTANDING = 4
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 inst_req,
   input  logic                 inst_wr,
   input  logic [SIZE_W-1:0]    inst_size,
   input  logic [ADDR_W-1:0]    inst_addr,
   input  logic [STRB_W-1:0]    inst_wstrb,
   input  logic [DATA_W-1:0]    inst_wdata,
   output logic                 inst_addrok,
   output logic                 inst_dataok,
   output logic [DATA_W-1:0]    inst_rdata,

   input  logic                 data_req,
   input  logic                 data_wr,
   input  logic [SIZE_W-1:0]    data_size,
   input  logic [ADDR_W-1:0]    data_addr,
   input  logic [STRB_W-1:0]    data_wstrb,
   input  logic [DATA_W-1:0]    data_wdata,
   output logic                 data_addrok,
   output logic                 data_dataok,
   output logic [DATA_W-1:0]    data_rdata,

   output logic                 mem_req,
   output logic                 mem_wr,
   output logic [SIZE_W-1:0]    mem_size,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [STRB_W-1:0]    mem_wstrb,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_addrok,
   input  logic                 mem_dataok,
   input  logic [DATA_W-1:0]    mem_rdata
);

   logic      lock_vld_q, lock_vld_d;
   logic      lock_id_q,  lock_id_d;
   logic      grant;
   logic      grant_req;
   logic      addr_hs;
   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_head;
   sram_req_t inst_bus;
   sram_req_t data_bus;
   sram_req_t sel_bus;

   // Grant: a held lock wins, otherwise data has priority over inst.
   always_comb begin
      if (lock_vld_q) begin
         grant = lock_id_q;
      end else if (data_req) begin
         grant = ID_DATA;
      end else begin
         grant = ID_INST;
      end
   end

   assign inst_bus = pack_req(inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata);
   assign data_bus = pack_req(data_wr, data_size, data_addr, data_wstrb, data_wdata);
   assign sel_bus  = (grant == ID_DATA) ? data_bus : inst_bus;

   assign grant_req = (grant == ID_DATA) ? data_req : inst_req;

   // Full comes from the registered count, so mem_dataok never reaches mem_req.
   assign mem_req   = grant_req && !fifo_full;
   assign mem_wr    = sel_bus.wr;
   assign mem_size  = sel_bus.size;
   assign mem_addr  = sel_bus.addr;
   assign mem_wstrb = sel_bus.wstrb;
   assign mem_wdata = sel_bus.wdata;

   assign addr_hs     = mem_req && mem_addrok;
   assign inst_addrok = addr_hs && (grant == ID_INST);
   assign data_addrok = addr_hs && (grant == ID_DATA);

   assign inst_dataok = mem_dataok && !fifo_empty && (fifo_head == ID_INST);
   assign data_dataok = mem_dataok && !fifo_empty && (fifo_head == ID_DATA);
   assign inst_rdata  = mem_rdata;
   assign data_rdata  = mem_rdata;

   // Lock next-state: set when a presented request stalls, clear on handshake.
   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      if (addr_hs) begin
         lock_vld_d = 1'b0;
      end else if (mem_req && !mem_addrok) begin
         lock_vld_d = 1'b1;
         lock_id_d  = grant;
      end
   end

   // Lock register.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_vld_q <= 1'b0;
         lock_id_q  <= ID_INST;
      end else begin
         lock_vld_q <= lock_vld_d;
         lock_id_q  <= lock_id_d;
      end
   end

   id_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (addr_hs),
      .pop_i   (mem_dataok),
      .din_i   (grant),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with an owner/rdata scoreboard.
module tb_sram_like_arbiter;

   localparam logic [31:0] IADDR = 32'hBFC0_0000;
   localparam logic [31:0] DADDR = 32'h8000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr, inst_addrok, inst_dataok;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata, inst_rdata;
   logic [3:0]  inst_wstrb;
   logic        data_req, data_wr, data_addrok, data_dataok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        mem_req, mem_wr, mem_addrok, mem_dataok;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   typedef struct {
      logic        id;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] next_rdata;

   always #5 clk = ~clk;

   sram_like_arbiter #(.OUTSTANDING(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
      .inst_addrok(inst_addrok), .inst_dataok(inst_dataok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addrok(data_addrok), .data_dataok(data_dataok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_addrok(mem_addrok), .mem_dataok(mem_dataok), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, pop scoreboard on dataok, check at negedge, push on handshake.
   task automatic cyc(input logic ir, input logic dr, input logic ao, input logic dok,
                      input logic emr, input logic eia, input logic eda, input logic eg,
                      input string tag);
      exp_t        e;
      logic        eidok, eddok;
      logic [31:0] rd;
      inst_req   = ir;
      data_req   = dr;
      mem_addrok = ao;
      mem_dataok = dok;
      eidok      = 1'b0;
      eddok      = 1'b0;
      rd         = 32'hDEAD_BEEF;
      if (dok && sb.size() > 0) begin
         e     = sb.pop_front();
         rd    = e.rdata;
         eidok = (e.id == 1'b0);
         eddok = (e.id == 1'b1);
      end
      mem_rdata = rd;
      @(negedge clk);
      chk({tag, ".mem_req"},     32'(mem_req),     32'(emr));
      chk({tag, ".inst_addrok"}, 32'(inst_addrok), 32'(eia));
      chk({tag, ".data_addrok"}, 32'(data_addrok), 32'(eda));
      chk({tag, ".inst_dataok"}, 32'(inst_dataok), 32'(eidok));
      chk({tag, ".data_dataok"}, 32'(data_dataok), 32'(eddok));
      chk({tag, ".mem_addr"},    mem_addr,         eg ? DADDR : IADDR);
      chk({tag, ".mem_wr"},      32'(mem_wr),      32'(eg));
      if (dok) begin
         chk({tag, ".inst_rdata"}, inst_rdata, rd);
         chk({tag, ".data_rdata"}, data_rdata, rd);
      end
      if (eia) begin
         sb.push_back('{id: 1'b0, rdata: next_rdata});
         next_rdata = next_rdata + 32'h0101_0101;
      end
      if (eda) begin
         sb.push_back('{id: 1'b1, rdata: next_rdata});
         next_rdata = next_rdata + 32'h0101_0101;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      reset      = 1'b1;
      inst_req   = 1'b0;
      data_req   = 1'b0;
      mem_addrok = 1'b0;
      mem_dataok = 1'b0;
      @(negedge clk);
      chk({tag, ".mem_req"},     32'(mem_req),     32'd0);
      chk({tag, ".inst_addrok"}, 32'(inst_addrok), 32'd0);
      chk({tag, ".data_addrok"}, 32'(data_addrok), 32'd0);
      chk({tag, ".inst_dataok"}, 32'(inst_dataok), 32'd0);
      chk({tag, ".data_dataok"}, 32'(data_dataok), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
   endtask

   initial begin
      inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IADDR; inst_wstrb = 4'h0; inst_wdata = 32'h0;
      data_wr = 1'b1; data_size = 2'd2; data_addr = DADDR; data_wstrb = 4'hF; data_wdata = 32'h5A5A_A5A5;
      mem_rdata  = 32'h0;
      next_rdata = 32'h3C1D_0010;

      do_reset("rst");

      //            ir dr ao dk emr eia eda eg
      // single read
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "rd.c0");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "rd.c1");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "rd.c2");

      // priority + lock on data
      cyc(1, 1, 0, 0, 1, 0, 0, 1, "pri.c0");
      cyc(1, 1, 0, 0, 1, 0, 0, 1, "pri.c1");
      cyc(1, 1, 1, 0, 1, 0, 1, 1, "pri.c2");
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "pri.c3");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "pri.d0");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "pri.d1");

      // lock on inst holds against a later data request
      cyc(1, 0, 0, 0, 1, 0, 0, 0, "lk.c0");
      cyc(1, 1, 0, 0, 1, 0, 0, 0, "lk.c1");
      cyc(1, 1, 1, 0, 1, 1, 0, 0, "lk.c2");
      cyc(1, 1, 1, 0, 1, 0, 1, 1, "lk.c3");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "lk.d0");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "lk.d1");

      // in-order routing
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "ord.c0");
      cyc(0, 1, 1, 0, 1, 0, 1, 1, "ord.c1");
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "ord.c2");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "ord.d0");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "ord.d1");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "ord.d2");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "ord.spur");

      // full gating
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "full.h0");
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "full.h1");
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "full.h2");
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "full.h3");
      cyc(1, 0, 1, 0, 0, 0, 0, 0, "full.blk");
      cyc(1, 1, 1, 0, 0, 0, 0, 1, "full.blkd");
      cyc(1, 0, 1, 1, 0, 0, 0, 0, "full.pop");
      cyc(1, 0, 1, 1, 1, 1, 0, 0, "full.pp3");
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "full.h4");
      cyc(1, 0, 1, 0, 0, 0, 0, 0, "full.blk2");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "full.d0");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "full.d1");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "full.d2");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "full.d3");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "spur");

      // reset mid-operation: two outstanding and an inst lock held
      cyc(1, 0, 1, 0, 1, 1, 0, 0, "mr.h0");
      cyc(0, 1, 1, 0, 1, 0, 1, 1, "mr.h1");
      cyc(1, 0, 0, 0, 1, 0, 0, 0, "mr.lk");
      do_reset("mr.rst");
      cyc(1, 1, 0, 0, 1, 0, 0, 1, "mr.pri");
      cyc(0, 0, 0, 1, 0, 0, 0, 1, "mr.spur");
      cyc(1, 1, 1, 0, 1, 0, 1, 1, "mr.hs");
      cyc(0, 0, 0, 1, 0, 0, 0, 0, "mr.d0");

      chk("sb.empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master, one-slave arbiter for the SRAM-like bus. It merges the core's instruction port (`inst_sram_*`) and data port (`data_sram_*`) onto a single SRAM-like slave port that feeds the AXI bridge. It grants the address phase, records which master owns each outstanding transaction in an in-order ID FIFO, and routes `dataok` and `rdata` back to the owning master.

## Interface
- `OUTSTANDING`, default 4: maximum in-flight transactions; power of 2, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_req`, `inst_wr`  in  1 each  master 0 request and write flag.
- `inst_size`  in  2  master 0 transfer size.
- `inst_addr`  in  32  master 0 address.
- `inst_wstrb`  in  4  master 0 byte strobes.
- `inst_wdata`  in  32  master 0 write data.
- `inst_addrok`, `inst_dataok`  out  1 each  master 0 address and data handshakes.
- `inst_rdata`  out  32  master 0 read data.
- `data_*`  same set, same widths  master 1 (data port).
- `mem_req`, `mem_wr`, `mem_size`, `mem_addr`, `mem_wstrb`, `mem_wdata`  out  1/1/2/32/4/32  slave request fields.
- `mem_addrok`, `mem_dataok`  in  1 each  slave handshakes.
- `mem_rdata`  in  32  slave read data.

## Operation
- **Address handshake:** completes in any cycle where `mem_req && mem_addrok`.
- **Grant when unlocked:** data master wins if `data_req`; otherwise inst master wins if `inst_req`.
- **Lock:** if the granted request is presented and `mem_addrok` is low, set `lock_vld` and `lock_id`.
  - While locked, the grant stays with `lock_id` regardless of the other master.
  - Lock clears on the address handshake.
- **FIFO-full gating:** when the ID FIFO is full, `mem_req` is 0 and both master `addrok` are 0.
  - A pending lock is held.
  - `mem_*` fields still reflect the granted master.
- **Request mux:** `mem_*` request fields are a pure mux of the granted master's fields.
  - `mem_req` = granted master's req && !full.
  - `X_addrok` = `mem_addrok` && `mem_req` && grant==X.
- **Push:** on the address handshake, push the grant ID (0 = inst, 1 = data).
- **Pop:** on `mem_dataok`, pop the head.
  - Routing: `X_dataok` = `mem_dataok` && !empty && head==X.
  - `inst_rdata` and `data_rdata` both carry `mem_rdata` unconditionally.
- **Push and pop together:** the count is unchanged. When full, push is already blocked, so only the pop occurs.
- **`mem_dataok` while empty:** protocol violation. No pop, no `dataok` to any master, FIFO pointers unchanged.
- **Ordering:** responses follow address-handshake order. The slave is required to return data in order.
- **Reset:** FIFO pointers and count go to 0, `lock_vld` to 0.
  - Outputs after reset: `mem_req`=0, all `addrok`/`dataok`=0.
  - Reset mid-transaction discards all outstanding IDs; the slave is reset in the same cycle.

## Timing
- Zero-cycle combinational paths:
  - `X_req` → `mem_req`, `mem_addrok` → `X_addrok`, `mem_dataok` → `X_dataok`.
- No combinational path from `mem_dataok` to `mem_req`, because full is taken from registered count.
- Earliest response: `X_dataok` for a transaction can assert in the cycle after its address handshake. It cannot assert in the same cycle, because the push is visible only after the edge.
- Throughput: one address handshake per cycle, and one `dataok` per cycle.
- Count width is clog2(`OUTSTANDING`)+1; pointers wrap modulo `OUTSTANDING`.

## Structure
- Shared package `sram_like_pkg`:
  - master-ID constants `ID_INST`=0 and `ID_DATA`=1;
  - widths (addr 32, data 32, size 2, strb 4);
  - `SRAM_REQ_BUS_WD` = 71, for packing request fields.
- One sub-module, `id_fifo`:
  - parameterised depth, 1-bit payload;
  - push, pop, full, empty and head outputs;
  - synchronous active-high reset.
- Top level holds the lock register and the combinational muxes.

## Test plan
- **Single read.** `inst_req` with addr 0xBFC00000; slave gives `addrok` at cycle 0 and `dataok` at cycle 2 with `rdata` 0x3C1D0010.
  - Expect `inst_addrok` at cycle 0, `inst_dataok` at cycle 2 with that data, and `data_dataok` never asserted.
- **Priority and lock.** Both masters request in cycle 0 and the slave withholds `addrok` for 2 cycles.
  - Expect data granted and held; `inst_addrok`=0 throughout.
  - After the data handshake, inst is granted the next cycle.
- **In-order routing.** Handshake order inst, data, inst, then `dataok` on 3 consecutive cycles.
  - Expect `inst_dataok`, `data_dataok`, `inst_dataok` in that order, with count returning to 0.
- **Full.** `OUTSTANDING`=4, issue 4 handshakes with no `dataok`.
  - Expect `mem_req`=0 while the 5th request is pending.
  - In the cycle after the first `dataok`, the 5th is accepted.
  - Simultaneous pop and push at count 3 leaves count at 3.
- **Spurious dataok.** `mem_dataok` pulsed with the FIFO empty.
  - Expect no master `dataok` and count stays 0.
- **Reset mid-operation.** Assert `reset` with 2 IDs outstanding and a lock held.
  - Next cycle: count 0, no lock, `mem_req` follows the new requests, and data priority applies again.
